// File: rtl/galaksija_kbd_pkg.sv
// Shared keyboard definitions: ps2_key layout, set-2 scancodes, FSM encodings.
package galaksija_kbd_pkg;

  // ps2_key bit positions
  localparam int PS2_TOG   = 10;
  localparam int PS2_PRESS = 9;
  localparam int PS2_EXT   = 8;

  localparam logic [7:0] SC_LSHIFT = 8'h12;
  localparam logic [7:0] SC_ENTER  = 8'h5A;
  localparam logic [7:0] SC_SPACE  = 8'h29;
  localparam logic [7:0] SC_BKSP   = 8'h66;

  // a..z
  localparam logic [7:0] SC_LETTER [26] = '{
    8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33, 8'h43, 8'h3B,
    8'h42, 8'h4B, 8'h3A, 8'h31, 8'h44, 8'h4D, 8'h15, 8'h2D, 8'h1B, 8'h2C,
    8'h3C, 8'h2A, 8'h1D, 8'h22, 8'h35, 8'h1A};

  // 0..9
  localparam logic [7:0] SC_DIGIT [10] = '{
    8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46};

  // Result of the ascii lookup
  typedef struct packed {
    logic       valid;
    logic       shift;
    logic       ext;
    logic [7:0] code;
  } xlat_t;

  typedef enum logic [2:0] {
    T_IDLE, T_SHIFT_DN, T_KEY_DN, T_KEY_UP, T_SHIFT_UP, T_GAP
  } xlat_state_t;

  typedef enum logic [1:0] {
    RX_IDLE, RX_START, RX_DATA, RX_STOP
  } rx_state_t;

endpackage

// File: rtl/uart_rx_8n1.sv
// 8N1 receiver: 2-FF synchronizer, mid-bit sampling, byte + valid / frame_err strobes.
module uart_rx_8n1
  import galaksija_kbd_pkg::*;
#(
  parameter int CLKS_PER_BIT = 217
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx,
  output logic [7:0] data,
  output logic       valid,
  output logic       frame_err
);

  localparam int CW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] HALF_LD = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] BIT_LD  = CW'(CLKS_PER_BIT - 1);

  rx_state_t     st, nxt;
  logic [1:0]    sync;
  logic          s, s_prev;
  logic [CW-1:0] cnt, cnt_val;
  logic          cnt_ld;
  logic [2:0]    bit_idx;
  logic [7:0]    shreg;
  logic          smp, vld, ferr;

  assign s    = sync[1];
  assign data = shreg;

  // Synchronize rx and keep the previous value for falling-edge detection
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync   <= 2'b11;
      s_prev <= 1'b1;
    end else begin
      sync   <= {sync[0], rx};
      s_prev <= s;
    end
  end

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) st <= RX_IDLE;
    else       st <= nxt;
  end

  // Next state: each phase waits for the bit counter to hit zero, then samples
  always_comb begin
    nxt     = st;
    cnt_ld  = 1'b0;
    cnt_val = '0;
    smp     = 1'b0;
    vld     = 1'b0;
    ferr    = 1'b0;
    case (st)
      RX_IDLE: if (s_prev && !s) begin
        nxt = RX_START; cnt_ld = 1'b1; cnt_val = HALF_LD;
      end
      RX_START: if (cnt == '0) begin
        if (s) nxt = RX_IDLE;           // too short to be a start bit
        else begin
          nxt = RX_DATA; cnt_ld = 1'b1; cnt_val = BIT_LD;
        end
      end
      RX_DATA: if (cnt == '0) begin
        smp = 1'b1; cnt_ld = 1'b1; cnt_val = BIT_LD;
        if (bit_idx == 3'd7) nxt = RX_STOP;
      end
      RX_STOP: if (cnt == '0) begin
        nxt = RX_IDLE;
        if (s) vld  = 1'b1;
        else   ferr = 1'b1;
      end
      default: nxt = RX_IDLE;
    endcase
  end

  // Bit divider, bit index and LSB-first shift register; strobes registered
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt       <= '0;
      bit_idx   <= '0;
      shreg     <= '0;
      valid     <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      if (cnt_ld)          cnt <= cnt_val;
      else if (cnt != '0)  cnt <= cnt - 1'b1;
      if (st == RX_START)  bit_idx <= '0;
      else if (smp)        bit_idx <= bit_idx + 1'b1;
      if (smp)             shreg <= {s, shreg[7:1]};
      valid     <= vld;
      frame_err <= ferr;
    end
  end

endmodule

// File: rtl/serial_keyboard.sv
// Serial-to-ps2_key bridge: UART RX -> byte FIFO -> ascii lookup -> timed key events.
module serial_keyboard
  import galaksija_kbd_pkg::*;
#(
  parameter int f_clk           = 25000000,
  parameter int baud            = 115200,
  parameter int fifo_depth_log2 = 4,
  parameter int press_cycles    = 1000000,
  parameter int gap_cycles      = 1000000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        rx,
  output logic [10:0] ps2_key,
  output logic        busy,
  output logic        overflow,
  output logic        frame_err,
  input  logic        clear_flags
);

  localparam int DEPTH = 1 << fifo_depth_log2;
  localparam int LW    = fifo_depth_log2 + 1;
  localparam int TMAX  = (press_cycles > gap_cycles) ? press_cycles : gap_cycles;
  localparam int TW    = $clog2(TMAX + 1);
  // The emit cycle and the transition cycle each take one clock, so the
  // counter is loaded two short to space toggles exactly by the nominal count.
  localparam logic [TW-1:0] PRESS_LD = TW'(press_cycles - 2);
  localparam logic [TW-1:0] GAP_LD   = TW'(gap_cycles - 2);

  // ascii -> {valid, shift, ext, code}
  function automatic xlat_t mk(input logic sh, input logic [7:0] code);
    return {1'b1, sh, 1'b0, code};
  endfunction

  function automatic xlat_t ascii_xlat(input logic [7:0] c);
    xlat_t r;
    r = '0;
    if (c >= 8'h61 && c <= 8'h7A)      r = mk(1'b0, SC_LETTER[c[4:0] - 5'd1]);
    else if (c >= 8'h41 && c <= 8'h5A) r = mk(1'b0, SC_LETTER[c[4:0] - 5'd1]);
    else if (c >= 8'h30 && c <= 8'h39) r = mk(1'b0, SC_DIGIT[c[3:0]]);
    else begin
      case (c)
        8'h20: r = mk(1'b0, SC_SPACE);
        8'h0D: r = mk(1'b0, SC_ENTER);
        8'h08: r = mk(1'b0, SC_BKSP);
        8'h21: r = mk(1'b1, 8'h16);  // !
        8'h22: r = mk(1'b1, 8'h52);  // "
        8'h23: r = mk(1'b1, 8'h26);  // #
        8'h24: r = mk(1'b1, 8'h25);  // $
        8'h25: r = mk(1'b1, 8'h2E);  // %
        8'h26: r = mk(1'b1, 8'h3D);  // &
        8'h27: r = mk(1'b0, 8'h52);  // '
        8'h28: r = mk(1'b1, 8'h46);  // (
        8'h29: r = mk(1'b1, 8'h45);  // )
        8'h2A: r = mk(1'b1, 8'h3E);  // *
        8'h2B: r = mk(1'b1, 8'h55);  // +
        8'h2C: r = mk(1'b0, 8'h41);  // ,
        8'h2D: r = mk(1'b0, 8'h4E);  // -
        8'h2E: r = mk(1'b0, 8'h49);  // .
        8'h2F: r = mk(1'b0, 8'h4A);  // /
        8'h3A: r = mk(1'b1, 8'h4C);  // :
        8'h3B: r = mk(1'b0, 8'h4C);  // ;
        8'h3C: r = mk(1'b1, 8'h41);  // <
        8'h3D: r = mk(1'b0, 8'h55);  // =
        8'h3E: r = mk(1'b1, 8'h49);  // >
        8'h3F: r = mk(1'b1, 8'h4A);  // ?
        8'h40: r = mk(1'b1, 8'h1E);  // @
        default: r = '0;
      endcase
    end
    return r;
  endfunction

  logic [7:0] rx_data;
  logic       rx_vld, rx_ferr;

  uart_rx_8n1 #(.CLKS_PER_BIT(f_clk / baud)) u_rx (
    .clk       (clk),
    .reset     (reset),
    .rx        (rx),
    .data      (rx_data),
    .valid     (rx_vld),
    .frame_err (rx_ferr)
  );

  // ---------------- FIFO ----------------
  logic [7:0]                 mem [DEPTH];
  logic [fifo_depth_log2-1:0] wp, rp;
  logic [LW-1:0]              lvl;
  logic                       full, empty, push, pop;

  assign full  = (lvl == LW'(DEPTH));
  assign empty = (lvl == '0);
  assign push  = rx_vld && !full;

  // Storage needs no reset; only pointers and level define contents
  always_ff @(posedge clk) begin
    if (push) mem[wp] <= rx_data;
  end

  // Pointers and level; push+pop together leaves the level alone
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wp  <= '0;
      rp  <= '0;
      lvl <= '0;
    end else begin
      if (push) wp <= wp + 1'b1;
      if (pop)  rp <= rp + 1'b1;
      if (push && !pop)      lvl <= lvl + 1'b1;
      else if (pop && !push) lvl <= lvl - 1'b1;
    end
  end

  // Sticky error flags; a new error wins over a same-cycle clear
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      overflow  <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      if (rx_vld && full) overflow <= 1'b1;
      else if (clear_flags) overflow <= 1'b0;
      if (rx_ferr) frame_err <= 1'b1;
      else if (clear_flags) frame_err <= 1'b0;
    end
  end

  // ---------------- translator ----------------
  xlat_state_t st, nxt;
  xlat_t       head_x, cur;
  logic        fresh;           // first cycle in the current state
  logic [TW-1:0] tmr, tmr_val;
  logic        tmr_ld, emit;
  logic [9:0]  ev;

  assign head_x = ascii_xlat(mem[rp]);
  assign busy   = (st != T_IDLE) || !empty;

  // State register, entry flag and the key being typed
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      st    <= T_IDLE;
      fresh <= 1'b0;
      cur   <= '0;
    end else begin
      st    <= nxt;
      fresh <= (nxt != st);
      if (pop) cur <= head_x;
    end
  end

  // Event sequencing: emit and load the timer on entry, advance when it expires
  always_comb begin
    nxt     = st;
    pop     = 1'b0;
    emit    = 1'b0;
    ev      = '0;
    tmr_ld  = 1'b0;
    tmr_val = '0;
    case (st)
      T_IDLE: if (!empty) begin
        pop = 1'b1;
        if (head_x.valid) nxt = head_x.shift ? T_SHIFT_DN : T_KEY_DN;
      end
      T_SHIFT_DN: begin
        if (fresh) begin
          emit = 1'b1; ev = {1'b1, 1'b0, SC_LSHIFT}; tmr_ld = 1'b1; tmr_val = GAP_LD;
        end else if (tmr == '0) nxt = T_KEY_DN;
      end
      T_KEY_DN: begin
        if (fresh) begin
          emit = 1'b1; ev = {1'b1, cur.ext, cur.code}; tmr_ld = 1'b1; tmr_val = PRESS_LD;
        end else if (tmr == '0) nxt = T_KEY_UP;
      end
      T_KEY_UP: begin
        if (fresh) begin
          emit = 1'b1; ev = {1'b0, cur.ext, cur.code}; tmr_ld = 1'b1; tmr_val = GAP_LD;
        end else if (tmr == '0) nxt = cur.shift ? T_SHIFT_UP : T_GAP;
      end
      T_SHIFT_UP: begin
        if (fresh) begin
          emit = 1'b1; ev = {1'b0, 1'b0, SC_LSHIFT}; tmr_ld = 1'b1; tmr_val = GAP_LD;
        end else if (tmr == '0) nxt = T_IDLE;
      end
      T_GAP:   nxt = T_IDLE;
      default: nxt = T_IDLE;
    endcase
  end

  // Hold/gap down-counter
  always_ff @(posedge clk or posedge reset) begin
    if (reset)           tmr <= '0;
    else if (tmr_ld)     tmr <= tmr_val;
    else if (tmr != '0)  tmr <= tmr - 1'b1;
  end

  // ps2_key output: new payload plus toggle bit flip per event
  always_ff @(posedge clk or posedge reset) begin
    if (reset)     ps2_key <= '0;
    else if (emit) ps2_key <= {~ps2_key[PS2_TOG], ev};
  end

endmodule

// File: tb/tb_serial_keyboard.sv
// Bench for serial_keyboard: byte table + scoreboard of expected ps2_key events.
module tb_serial_keyboard;

  localparam int FCLK = 25000000;
  localparam int BAUD = FCLK / 16;
  localparam int BITC = 16;

  logic        clk = 1'b0;
  logic        reset, rx, rx2, clear_flags, clear_flags2;
  logic [10:0] ps2_key, ps2_key2;
  logic        busy, busy2, overflow, overflow2, frame_err, frame_err2;

  serial_keyboard #(.f_clk(FCLK), .baud(BAUD), .fifo_depth_log2(4),
                    .press_cycles(100), .gap_cycles(50)) u_dut (
    .clk(clk), .reset(reset), .rx(rx), .ps2_key(ps2_key), .busy(busy),
    .overflow(overflow), .frame_err(frame_err), .clear_flags(clear_flags));

  // Slow-typing instance: one key outlasts 18 serial bytes, so the FIFO fills
  serial_keyboard #(.f_clk(FCLK), .baud(BAUD), .fifo_depth_log2(4),
                    .press_cycles(2000), .gap_cycles(1000)) u_ovf (
    .clk(clk), .reset(reset), .rx(rx2), .ps2_key(ps2_key2), .busy(busy2),
    .overflow(overflow2), .frame_err(frame_err2), .clear_flags(clear_flags2));

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int npass = 0, ntot = 0;

  task automatic chk(input string nm, input int act, input int exp);
    ntot++;
    if (act == exp) npass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
  endtask

  typedef struct {
    logic [9:0] v;
    int         sp;   // required clocks since previous event, 0 = unchecked
  } ev_t;
  ev_t evq[$];
  logic [7:0] q2[$];

  // Scoreboard for the main instance
  logic tog_prev = 1'b0;
  int   last_cyc = 0, ntog = 0;
  always @(negedge clk) begin
    if (reset) tog_prev = ps2_key[10];
    else if (ps2_key[10] != tog_prev) begin
      ev_t e;
      tog_prev = ps2_key[10];
      ntog++;
      if (evq.size() == 0) begin
        ntot++;
        $display("FAIL unexpected_event: got 0x%0h expected none", ps2_key[9:0]);
      end else begin
        e = evq.pop_front();
        chk("ev_val", int'(ps2_key[9:0]), int'(e.v));
        if (e.sp != 0) chk("ev_spacing", cyc - last_cyc, e.sp);
      end
      last_cyc = cyc;
    end
  end

  // Press order for the overflow instance
  logic tog2_prev = 1'b0;
  always @(negedge clk) begin
    if (reset) tog2_prev = ps2_key2[10];
    else if (ps2_key2[10] != tog2_prev) begin
      tog2_prev = ps2_key2[10];
      if (ps2_key2[9]) begin
        if (q2.size() == 0) begin
          ntot++;
          $display("FAIL ovf_unexpected: got 0x%0h expected none", ps2_key2[7:0]);
        end else chk("ovf_order", int'(ps2_key2[7:0]), int'(q2.pop_front()));
      end
    end
  end

  task automatic send(input logic [7:0] b, input logic stopv, input bit which);
    logic [9:0] fr;
    fr = {stopv, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (which) rx2 = fr[i]; else rx = fr[i];
      repeat (BITC - 1) @(negedge clk);
    end
    @(negedge clk);
    if (which) rx2 = 1'b1; else rx = 1'b1;
  endtask

  task automatic wait_idle(input bit which, input int bound);
    int i;
    for (i = 0; i < bound; i++) begin
      if (!(which ? busy2 : busy)) break;
      @(negedge clk);
    end
    if (i == bound) begin
      ntot++;
      $display("FAIL idle_timeout: busy still 1 after %0d cycles, required 0", bound);
    end
  endtask

  task automatic push_key(input logic sh, input logic [7:0] code);
    if (sh) begin
      evq.push_back('{10'h212, 0});
      evq.push_back('{{2'b10, code}, 50});
      evq.push_back('{{2'b00, code}, 100});
      evq.push_back('{10'h012, 50});
    end else begin
      evq.push_back('{{2'b10, code}, 0});
      evq.push_back('{{2'b00, code}, 100});
    end
  endtask

  typedef struct {
    logic [7:0] ch;
    logic       vld;
    logic       sh;
    logic [7:0] code;
  } vec_t;
  vec_t tbl[12];

  logic [7:0] ovf_codes[17];

  initial begin
    int n0;
    tbl[0]  = '{8'h41, 1'b1, 1'b0, 8'h1C};  // A
    tbl[1]  = '{8'h7A, 1'b1, 1'b0, 8'h1A};  // z
    tbl[2]  = '{8'h21, 1'b1, 1'b1, 8'h16};  // !
    tbl[3]  = '{8'h0A, 1'b0, 1'b0, 8'h00};  // LF
    tbl[4]  = '{8'h0D, 1'b1, 1'b0, 8'h5A};  // CR
    tbl[5]  = '{8'h37, 1'b1, 1'b0, 8'h3D};  // 7
    tbl[6]  = '{8'h20, 1'b1, 1'b0, 8'h29};  // space
    tbl[7]  = '{8'h08, 1'b1, 1'b0, 8'h66};  // BS
    tbl[8]  = '{8'h3F, 1'b1, 1'b1, 8'h4A};  // ?
    tbl[9]  = '{8'h2E, 1'b1, 1'b0, 8'h49};  // .
    tbl[10] = '{8'h30, 1'b1, 1'b0, 8'h45};  // 0
    tbl[11] = '{8'h01, 1'b0, 1'b0, 8'h00};  // control code
    ovf_codes = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33, 8'h43,
                  8'h3B, 8'h42, 8'h4B, 8'h3A, 8'h31, 8'h44, 8'h4D, 8'h15};

    reset = 1'b1; rx = 1'b1; rx2 = 1'b1; clear_flags = 1'b0; clear_flags2 = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_ps2_key", int'(ps2_key), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_overflow", int'(overflow), 0);
    chk("rst_frame_err", int'(frame_err), 0);
    reset = 1'b0;
    repeat (5) @(negedge clk);

    // 'A': busy drops 50 clocks after the release event
    push_key(1'b0, 8'h1C);
    send(8'h41, 1'b1, 1'b0);
    wait_idle(1'b0, 2000);
    chk("busy_fall", cyc - last_cyc, 50);

    // Table of single bytes
    foreach (tbl[i]) begin
      n0 = ntog;
      if (tbl[i].vld) push_key(tbl[i].sh, tbl[i].code);
      send(tbl[i].ch, 1'b1, 1'b0);
      wait_idle(1'b0, 2000);
      repeat (4) @(negedge clk);
      chk($sformatf("tbl%0d_events", i), ntog - n0,
          !tbl[i].vld ? 0 : (tbl[i].sh ? 4 : 2));
    end

    // Stop bit low: byte dropped, frame_err set, then cleared
    n0 = ntog;
    send(8'h31, 1'b0, 1'b0);
    repeat (40) @(negedge clk);
    chk("ferr_set", int'(frame_err), 1);
    chk("ferr_no_event", ntog - n0, 0);
    chk("ferr_busy", int'(busy), 0);
    clear_flags = 1'b1;
    @(negedge clk);
    clear_flags = 1'b0;
    chk("ferr_clear", int'(frame_err), 0);

    // Quarter-bit glitch: nothing received
    rx = 1'b0;
    repeat (BITC / 4) @(negedge clk);
    rx = 1'b1;
    repeat (60) @(negedge clk);
    chk("glitch_busy", int'(busy), 0);
    chk("glitch_ferr", int'(frame_err), 0);
    chk("glitch_no_event", ntog - n0, 0);

    // Reset during the key-down hold
    n0 = ntog;
    push_key(1'b0, 8'h1C);
    send(8'h41, 1'b1, 1'b0);
    for (int i = 0; i < 500 && ntog == n0; i++) @(negedge clk);
    chk("rst_press_seen", ntog - n0, 1);
    repeat (20) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    chk("midrst_ps2_key", int'(ps2_key), 0);
    chk("midrst_busy", int'(busy), 0);
    evq.delete();
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (5) @(negedge clk);
    push_key(1'b0, 8'h3D);
    send(8'h37, 1'b1, 1'b0);
    wait_idle(1'b0, 2000);
    chk("after_rst_drained", evq.size(), 0);
    chk("main_overflow", int'(overflow), 0);

    // Overflow: primer '1' occupies the translator, then 17 letters
    // a..q back-to-back; 16 fit in the FIFO and 'q' is dropped.
    q2.push_back(8'h16);
    for (int i = 0; i < 16; i++) q2.push_back(ovf_codes[i]);
    send(8'h31, 1'b1, 1'b1);
    for (int i = 0; i < 17; i++) begin
      logic [7:0] c;
      c = 8'h61 + 8'(i);
      send(c, 1'b1, 1'b1);
    end
    repeat (20) @(negedge clk);
    chk("ovf_set", int'(overflow2), 1);
    clear_flags2 = 1'b1;
    @(negedge clk);
    clear_flags2 = 1'b0;
    chk("ovf_clear", int'(overflow2), 0);
    wait_idle(1'b1, 60000);
    chk("ovf_drained", q2.size(), 0);
    chk("ovf_ferr", int'(frame_err2), 0);

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule
